// File: rtl/debounce_pulse.sv
// debounce_pulse: synchronizes and debounces a bouncing input, emitting a clean level plus edge pulses.
//   Parameters: DEB_CYCLES - consecutive equal synchronized samples needed to accept a new level (2..255)
//               CNT_W      - debounce counter width, must hold DEB_CYCLES-1
//   Ports: clk    - rising-edge clock
//          rst_n  - asynchronous active-low reset
//          d      - raw asynchronous input
//          q      - registered debounced level
//          q_rise - one-cycle pulse on each accepted 0->1 change of q
//          q_fall - one-cycle pulse on each accepted 1->0 change of q
module debounce_pulse #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic q_rise,
    output logic q_fall
);
    typedef enum logic [1:0] {LOW, WAIT_H, HIGH, WAIT_L} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);
    logic             r_s1, r_s2;
    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_q, r_rise, r_fall;
    logic             w_done;
    // >= rather than == so a corrupted count still completes instead of wrapping
    assign w_done = r_cnt >= LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end
    always_comb begin
        w_state_nx = LOW;
        w_cnt_nx   = '0;
        case (r_state)
            LOW: begin
                if (r_s2) begin
                    w_state_nx = WAIT_H;
                    w_cnt_nx   = CNT_W'(1);
                end
            end
            WAIT_H: begin
                if (r_s2 && w_done) begin
                    w_state_nx = HIGH;
                end else if (r_s2) begin
                    w_state_nx = WAIT_H;
                    w_cnt_nx   = r_cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                w_state_nx = HIGH;
                if (!r_s2) begin
                    w_state_nx = WAIT_L;
                    w_cnt_nx   = CNT_W'(1);
                end
            end
            WAIT_L: begin
                if (r_s2) begin
                    w_state_nx = HIGH;
                end else if (!w_done) begin
                    w_state_nx = WAIT_L;
                    w_cnt_nx   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = LOW;
                w_cnt_nx   = '0;
            end
        endcase
    end
    // q and the pulses are registered from the next state so they change on the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_q     <= (w_state_nx == HIGH) || (w_state_nx == WAIT_L);
            r_rise  <= (r_state == WAIT_H) && (w_state_nx == HIGH);
            r_fall  <= (r_state == WAIT_L) && (w_state_nx == LOW);
        end
    end
    assign q      = r_q;
    assign q_rise = r_rise;
    assign q_fall = r_fall;
endmodule

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Upstream conditioning stage that produces the clean d input for the codebase's flip-flop/latch stages.

Interface
REQ-001 Parameter DEB_CYCLES, default 4, is the number of consecutive identical synchronized samples required to accept a new level; legal range 2..255.
REQ-002 Parameter CNT_W, default 8, is the debounce counter width; it SHALL hold DEB_CYCLES-1.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port d, input, 1 bit: raw asynchronous input (button or switch); may bounce.
REQ-006 Port q, output, 1 bit: registered debounced level.
REQ-007 Port q_rise, output, 1 bit: registered one-cycle pulse on each accepted 0->1 change of q.
REQ-008 Port q_fall, output, 1 bit: registered one-cycle pulse on each accepted 1->0 change of q.

Function
REQ-009 d SHALL pass through a two-flop synchronizer (s1, s2); only s2 feeds later logic.
REQ-010 The FSM SHALL have exactly four states: LOW, WAIT_H, HIGH, WAIT_L.
REQ-011 LOW: s2=1 -> WAIT_H with cnt=1; otherwise stay, cnt=0.
REQ-012 WAIT_H: s2=0 -> LOW with cnt=0; s2=1 and cnt<DEB_CYCLES-1 -> cnt+1; s2=1 and cnt=DEB_CYCLES-1 -> HIGH with cnt=0.
REQ-013 HIGH and WAIT_L SHALL mirror REQ-011/REQ-012 with the levels inverted.
REQ-014 q SHALL be 1 in HIGH and WAIT_L and 0 in LOW and WAIT_H; q is registered, not decoded combinationally.
REQ-015 q SHALL change on the edge at which s2 has shown the new level for DEB_CYCLES consecutive edges.
- Latency: DEB_CYCLES+1 edges after the first edge that samples the new d into s1.
- DEB_CYCLES=4: first sampling edge k -> q changes at edge k+5.
REQ-016 q_rise SHALL be 1 for exactly the one cycle following the LOW-side to HIGH transition (WAIT_H -> HIGH); otherwise 0.
REQ-017 q_fall SHALL be 1 for exactly the one cycle following the HIGH-side to LOW transition (WAIT_L -> LOW); otherwise 0.
REQ-018 q_rise and q_fall SHALL never be 1 in the same cycle.
REQ-019 Any glitch on s2 shorter than DEB_CYCLES samples SHALL return the FSM to its prior stable state, with no change on q, q_rise or q_fall.
REQ-020 cnt SHALL saturate at DEB_CYCLES-1 and never wrap; cnt SHALL be 0 in LOW and HIGH.
REQ-021 Unreachable state encodings SHALL recover to LOW with cnt=0 on the next edge.

Reset
REQ-022 On rst_n=0, these SHALL clear immediately, independent of clk: s1=0, s2=0, state=LOW, cnt=0, q=0, q_rise=0, q_fall=0.
REQ-023 While rst_n=0, all of these SHALL hold their reset values regardless of d.
REQ-024 On rst_n returning to 1, the first state update SHALL occur on the next rising clk edge.
REQ-025 Reset asserted during WAIT_H or WAIT_L SHALL abort the pending change; no pulse is emitted.

Verification (DEB_CYCLES=4, clk period 200, d changed mid-low-phase)
REQ-026 rst_n=0, d=1 for 3 cycles -> q=0, q_rise=0, q_fall=0 throughout.
REQ-027 After reset, d 0->1 held stable -> q=1 at the 5th edge after the first sampling edge; q_rise=1 for exactly that cycle; q_fall=0.
REQ-028 In HIGH, d pulses 0 for 2 cycles then back to 1 -> q stays 1; q_rise=0 and q_fall=0 throughout.
REQ-029 In HIGH, d 1->0 held stable -> q=0 five edges later; q_fall=1 for exactly one cycle.
REQ-030 d toggles every cycle for 20 cycles -> q unchanged; no pulses.
REQ-031 rst_n dropped mid-way between clk edges during WAIT_H -> q=0 and cnt=0 immediately; after release with d=1 held, q_rise occurs a full 5 edges after the first sampling edge.
